// File: rtl/mem_responder.sv
// mem_responder: word-organised on-chip memory behind valid/ready request and response
// channels, answering each request LATENCY+1 cycles after it is accepted.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        accept;
  assign off       = req_addr - BASE_ADDR;
  assign in_range  = (req_addr >= BASE_ADDR) && ({1'b0, off} < (33'(DEPTH_WORDS) << 2));
  assign idx       = off[AW+1:2];
  assign req_ready = state == IDLE;
  assign accept    = req_valid && req_ready;
  // Array is deliberately outside the reset domain so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_wen && in_range)
      for (int i = 0; i < 4; i++)
        if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
  // WAIT always spans LATENCY+1 cycles, so rsp_valid rises LATENCY+1 edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= WAIT;
          cnt       <= 4'(LATENCY);
          rsp_err   <= !in_range;
          rsp_rdata <= (!req_wen && in_range) ? mem[idx] : 32'd0;
        end
        WAIT: if (cnt == 4'd0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving a LATENCY=2 and a LATENCY=0 responder
// through one shared request/response port selected by sel.
module tb_mem_responder;
  logic clk = 0, rst_n = 0, sel = 0;
  logic req_valid = 0, req_wen = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_wmask = 0;
  logic rr2, rr0, rv2, rv0, re2, re0;
  logic [31:0] rd2, rd0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t exp_q[$];
  int acc_q[$];
  logic fresh = 1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rr2),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2));
  mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rr0),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0));
  assign req_ready = sel ? rr0 : rr2;
  assign rsp_valid = sel ? rv0 : rv2;
  assign rsp_rdata = sel ? rd0 : rd2;
  assign rsp_err   = sel ? re0 : re2;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      fresh = 1;
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
        else begin
          if (fresh) begin
            if (acc_q.size() == 0) check("latency_no_accept", 32'd0, 32'd1);
            else check("latency", 32'(cyc - acc_q.pop_front()), sel ? 32'd1 : 32'd3);
          end
          check("rsp_rdata", rsp_rdata, exp_q[0].d);
          check("rsp_err", 32'(rsp_err), 32'(exp_q[0].e));
          check("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            fresh = 1;
          end else fresh = 0;
        end
      end
    end
  end
  task automatic xact(input logic s, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] ed, input logic ee, input int bp);
    int k;
    sel = s;
    exp_q.push_back('{ed, ee});
    req_valid = 1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    rsp_ready = (bp == 0);
    k = 0;
    do @(negedge clk); while (!req_ready && ++k < 50);
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk) #1 req_valid = 0;
    k = 0;
    do @(negedge clk); while (!rsp_valid && ++k < 50);
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    if (bp > 0) begin
      repeat (bp - 1) @(negedge clk);
      @(posedge clk) #1 rsp_ready = 1;
      @(negedge clk);
    end
    @(posedge clk) #1;
    @(negedge clk);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    @(posedge clk) #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk) #1 rst_n = 1;
    @(posedge clk) #1;
    xact(0, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, 0);
    xact(0, 32'h8000_0010, 0, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 0);
    xact(0, 32'h8000_0020, 1, 32'h1122_3344, 4'hF, 32'd0, 0, 0);
    xact(0, 32'h8000_0020, 1, 32'hAABB_CCDD, 4'b0101, 32'd0, 0, 0);
    xact(0, 32'h8000_0020, 0, 32'd0, 4'h0, 32'h11BB_33DD, 0, 0);
    xact(0, 32'h8000_0010, 0, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 5);
    xact(0, 32'h8000_0010, 1, 32'h0BAD_0BAD, 4'h0, 32'd0, 0, 0);
    xact(0, 32'h8000_0010, 0, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 0);
    xact(0, 32'h8000_0000, 1, 32'hCAFE_F00D, 4'hF, 32'd0, 0, 0);
    xact(0, 32'h8000_0FFC, 1, 32'h0F0F_1234, 4'hF, 32'd0, 0, 0);
    xact(0, 32'h7FFF_FFFC, 0, 32'd0, 4'h0, 32'd0, 1, 0);
    xact(0, 32'h8000_1000, 0, 32'd0, 4'h0, 32'd0, 1, 0);
    xact(0, 32'h7FFF_FFFC, 1, 32'h5555_5555, 4'hF, 32'd0, 1, 0);
    xact(0, 32'h8000_1000, 1, 32'h6666_6666, 4'hF, 32'd0, 1, 0);
    xact(0, 32'h8000_0000, 0, 32'd0, 4'h0, 32'hCAFE_F00D, 0, 0);
    xact(0, 32'h8000_0FFC, 0, 32'd0, 4'h0, 32'h0F0F_1234, 0, 0);
    xact(1, 32'h8000_0010, 1, 32'h1234_5678, 4'hF, 32'd0, 0, 0);
    xact(1, 32'h8000_0013, 0, 32'd0, 4'h0, 32'h1234_5678, 0, 0);
    xact(1, 32'h8000_0010, 0, 32'd0, 4'h0, 32'h1234_5678, 0, 2);
    sel = 0;
    req_valid = 1; req_addr = 32'h8000_0030; req_wen = 1; req_wdata = 32'h5A5A_5A5A; req_wmask = 4'hF;
    @(negedge clk);
    check("abort_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk) #1 req_valid = 0;
    @(negedge clk);
    check("abort_in_wait", 32'(req_ready), 32'd0);
    @(posedge clk) #1 rst_n = 0;
    @(negedge clk);
    check("abort_reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk) #1 rst_n = 1;
    @(negedge clk);
    check("abort_release_ready", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clk);
    @(posedge clk) #1;
    xact(0, 32'h8000_0030, 0, 32'd0, 4'h0, 32'h5A5A_5A5A, 0, 0);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
